// File: rtl/tdm_demux_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_demux_pkg;

    // Frame alignment state: HUNT waits for a frame sync, LOCKED follows slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

    // Slot counter width. Clamped to 1 so that degenerate sizes stay legal.
    function automatic int slot_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: clear, load-to-1 (slot 0 just received) or increment with wrap.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int SW  = slot_width(NCH)
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          inc,
    input  logic          load1,
    input  logic          clr,
    output logic [SW-1:0] SLOT
);

    // Clear wins over load, load wins over increment.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            SLOT <= '0;
        end else if (clr) begin
            SLOT <= '0;
        end else if (load1) begin
            SLOT <= SW'(1);
        end else if (inc) begin
            if (SLOT == SW'(NCH - 1))
                SLOT <= '0;
            else
                SLOT <= SLOT + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: routes a slot-multiplexed word stream into per-channel
// holding registers, tracking frame alignment from the frame sync.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [W-1:0]     D,
    input  logic             DV,
    input  logic             FS,
    output logic [NCH*W-1:0] Q,
    output logic [NCH-1:0]   QV,
    output logic             FD,
    output logic             LOCK,
    output logic             ERR
);

    localparam int SW = slot_width(NCH);

    state_t             state;
    state_t             state_nxt;
    logic [SW-1:0]      slot;

    logic               wr_en;
    logic [SW-1:0]      wr_ch;
    logic               err_set;
    logic               ctr_inc;
    logic               ctr_load1;
    logic               ctr_clr;

    logic [NCH-1:0][W-1:0] q_r;

    tdm_slot_ctr #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_ctr (
        .CK    (CK),
        .RN    (RN),
        .inc   (ctr_inc),
        .load1 (ctr_load1),
        .clr   (ctr_clr),
        .SLOT  (slot)
    );

    // State register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    // Next state: sync acquires lock, a missing sync at slot 0 drops it.
    always_comb begin
        state_nxt = state;
        if (DV) begin
            case (state)
                HUNT:    if (FS) state_nxt = LOCKED;
                LOCKED:  if (!FS && slot == '0) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Per-word decisions: which channel to write, counter action, sync error.
    // An early sync restarts the frame (written as slot 0) but is flagged.
    always_comb begin
        wr_en     = 1'b0;
        wr_ch     = '0;
        err_set   = 1'b0;
        ctr_inc   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_clr   = 1'b0;
        if (DV) begin
            case (state)
                HUNT: begin
                    if (FS) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                    end
                end
                LOCKED: begin
                    if (FS) begin
                        wr_en     = 1'b1;
                        ctr_load1 = 1'b1;
                        err_set   = (slot != '0);
                    end else if (slot == '0) begin
                        err_set = 1'b1;
                        ctr_clr = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_ch   = slot;
                        ctr_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding registers and one-cycle strobes, all registered.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            q_r  <= '0;
            QV   <= '0;
            FD   <= 1'b0;
            LOCK <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                QV[k] <= wr_en && (wr_ch == SW'(k));
                if (wr_en && (wr_ch == SW'(k)))
                    q_r[k] <= D;
            end
            FD   <= wr_en && (wr_ch == SW'(NCH - 1));
            LOCK <= (state_nxt == LOCKED);
            ERR  <= err_set;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus pushes expected output events,
// a negedge monitor pops and compares whenever QV or ERR is presented.
module tb_tdm_demux;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             CK = 1'b0;
    logic             RN;
    logic [W-1:0]     D;
    logic             DV;
    logic             FS;
    logic [NCH*W-1:0] Q;
    logic [NCH-1:0]   QV;
    logic             FD;
    logic             LOCK;
    logic             ERR;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .CK   (CK),
        .RN   (RN),
        .D    (D),
        .DV   (DV),
        .FS   (FS),
        .Q    (Q),
        .QV   (QV),
        .FD   (FD),
        .LOCK (LOCK),
        .ERR  (ERR)
    );

    always #5 CK = ~CK;

    typedef struct {
        bit               qv;
        int               ch;
        logic [NCH*W-1:0] q;
        bit               err;
        bit               lock;
    } ev_t;

    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: alignment flag, expected position in frame, channel contents.
    bit         m_locked;
    int         m_pos;
    logic [W-1:0] m_ch[NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [NCH*W-1:0] m_qvec();
        logic [NCH*W-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*W +: W] = m_ch[k];
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
    endtask

    // Frame rules applied to one accepted word; pushes what the DUT must show.
    task automatic model_word(input logic [W-1:0] d, input bit fs);
        ev_t e;
        e.qv = 0; e.ch = 0; e.err = 0; e.lock = 0; e.q = '0;
        if (!m_locked) begin
            if (!fs) return;
            m_ch[0] = d; m_pos = 1; m_locked = 1;
            e.qv = 1; e.ch = 0;
        end else if (fs) begin
            e.err = (m_pos != 0);
            m_ch[0] = d; m_pos = 1;
            e.qv = 1; e.ch = 0;
        end else if (m_pos == 0) begin
            e.err = 1; m_locked = 0;
        end else begin
            m_ch[m_pos] = d;
            e.qv = 1; e.ch = m_pos;
            m_pos = (m_pos + 1) % NCH;
        end
        e.lock = m_locked;
        e.q    = m_qvec();
        exp_q.push_back(e);
    endtask

    // Present one word for one cycle, then idle for gap cycles with FS toggling.
    task automatic send(input logic [W-1:0] d, input bit fs, input int gap);
        D = d; FS = fs; DV = 1'b1;
        model_word(d, fs);
        @(posedge CK); #1;
        DV = 1'b0; FS = 1'($urandom); D = W'($urandom);
        repeat (gap) begin @(posedge CK); #1; end
    endtask

    task automatic settle();
        repeat (2) begin @(posedge CK); #1; end
    endtask

    // Monitor: compares every presented output event against the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge CK);
            if (RN === 1'b1 && (QV !== '0 || ERR !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_event", {QV, ERR}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("qv",   64'(QV),   e.qv ? 64'(1) << e.ch : 64'(0));
                    chk("err",  64'(ERR),  64'(e.err));
                    chk("fd",   64'(FD),   64'(e.qv && e.ch == NCH - 1));
                    chk("lock", 64'(LOCK), 64'(e.lock));
                    chk("q",    64'(Q),    64'(e.q));
                end
            end
        end
    end

    initial begin
        bit fs;
        RN = 1'b0; DV = 1'b0; FS = 1'b0; D = '0;
        model_reset();
        #12;
        chk("reset_outputs", {Q, QV, FD, LOCK, ERR}, '0);
        #1 RN = 1'b1;
        @(posedge CK); #1;

        // Unsynced words are dropped.
        send(8'hAA, 0, 0);
        send(8'hBB, 0, 0);
        settle();
        chk("hunt_lock", 64'(LOCK), 64'(0));
        chk("hunt_q",    64'(Q),    64'(0));

        // Basic frame, then missing sync drops lock.
        send(8'h11, 1, 0);
        send(8'h22, 0, 0);
        send(8'h33, 0, 0);
        send(8'h44, 0, 0);
        send(8'h66, 0, 0);
        settle();
        chk("after_missing_sync_lock", 64'(LOCK), 64'(0));

        // Early sync mid-frame restarts at slot 0.
        send(8'h01, 1, 0);
        send(8'h02, 0, 0);
        send(8'h55, 1, 0);
        send(8'h03, 0, 0);
        send(8'h04, 0, 0);
        send(8'h05, 0, 0);

        // Same frame with idle gaps.
        send(8'h11, 1, 3);
        send(8'h22, 0, 3);
        send(8'h33, 0, 3);
        send(8'h44, 0, 3);

        // Async reset mid-frame, then words until the next sync are dropped.
        send(8'h91, 1, 0);
        send(8'h92, 0, 0);
        @(negedge CK); #2;
        RN = 1'b0;
        #1;
        chk("async_reset_outputs", {Q, QV, FD, LOCK, ERR}, '0);
        model_reset();
        @(posedge CK); #1;
        RN = 1'b1;
        @(posedge CK); #1;
        send(8'h77, 0, 0);
        send(8'h88, 0, 0);
        settle();
        chk("post_reset_q", 64'(Q), 64'(0));
        send(8'hC0, 1, 0);
        send(8'hC1, 0, 1);

        // Random traffic: mostly well-formed frames with occasional sync faults.
        for (int i = 0; i < 400; i++) begin
            if (m_locked && m_pos == 0)
                fs = ($urandom_range(0, 9) != 0);
            else
                fs = ($urandom_range(0, 11) == 0);
            send(W'($urandom), fs, $urandom_range(0, 2));
        end

        settle();
        settle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of TDM channels (slots per frame, 2..16).
REQ-002 SHALL have parameter W, default 8, the data word width per slot.
REQ-003 SHALL have port CK, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port D, input, W, the time-multiplexed data word.
REQ-006 SHALL have port DV, input, 1, the word-valid qualifier; D and FS are sampled only when DV=1.
REQ-007 SHALL have port FS, input, 1, frame sync; when high with DV=1, the word is slot 0.
REQ-008 SHALL have port Q, output, NCH*W, per-channel holding registers; channel k occupies bits [k*W+W-1 : k*W].
REQ-009 SHALL have port QV, output, NCH, per-channel one-cycle update strobe.
REQ-010 SHALL have port FD, output, 1, frame-done pulse, asserted together with QV[NCH-1].
REQ-011 SHALL have port LOCK, output, 1, high while frame alignment is held.
REQ-012 SHALL have port ERR, output, 1, one-cycle sync-error pulse.

Function
REQ-013 SHALL implement a two-state FSM: HUNT and LOCKED, plus a slot counter SLOT of width clog2(NCH).
REQ-014 In HUNT, words with DV=1 and FS=0 SHALL be discarded; no QV, no ERR.
REQ-015 In HUNT, DV=1 and FS=1 SHALL write D to channel 0, set SLOT=1, and enter LOCKED.
REQ-016 In LOCKED, DV=1 and FS=0 SHALL write D to channel SLOT; SLOT increments, wrapping from NCH-1 to 0.
REQ-017 In LOCKED with SLOT=0, DV=1 and FS=0 (missing sync) SHALL discard the word, pulse ERR, and enter HUNT.
REQ-018 In LOCKED with SLOT!=0, DV=1 and FS=1 (early sync) SHALL pulse ERR, write D to channel 0, set SLOT=1, and stay LOCKED.
REQ-019 In LOCKED with SLOT=0, DV=1 and FS=1 SHALL be normal slot-0 reception.
REQ-020 DV=0 SHALL hold SLOT, state and Q; FS is ignored.
REQ-021 Latency: Q[k] and QV[k] SHALL update on the first rising CK edge after the accepted word is sampled; QV is a single-cycle pulse per accepted word.
REQ-022 At most one QV bit SHALL be high in any cycle; channels not written SHALL hold their value.
REQ-023 FD SHALL pulse in the same cycle as QV[NCH-1].
REQ-024 LOCK SHALL be a registered decode of state LOCKED.
REQ-025 ERR and QV SHALL be registered and SHALL never be high in the same cycle for the discarded-word case (REQ-017).

Reset
REQ-026 RN=0 SHALL immediately force HUNT, SLOT=0, Q=0, QV=0, FD=0, LOCK=0 and ERR=0, regardless of CK.
REQ-027 Reset deassertion mid-frame SHALL require a fresh FS before any QV; words sampled before that are discarded.

Structure
REQ-028 Package tdm_demux_pkg SHALL hold the state enum (HUNT, LOCKED) and the default NCH/W constants.
REQ-029 The slot counter with wrap and load-to-1 SHALL be a sub-module, tdm_slot_ctr (inputs: inc, load1, clr; output: SLOT); all other logic is flat in tdm_demux.

Verification
REQ-030 Reset, then DV=1, FS=1, D=0x11, followed by 0x22, 0x33, 0x44 -> Q={0x44,0x33,0x22,0x11}; QV pulses bits 0,1,2,3 on consecutive cycles; FD with QV[3]; LOCK=1 after the first word.
REQ-031 Words 0xAA, 0xBB with FS=0 before any sync -> no QV, no ERR, LOCK=0, Q stays 0.
REQ-032 Locked, after slots 0 and 1 a word 0x55 arrives with FS=1 -> ERR pulse, Q[0]=0x55, QV[0], next word goes to channel 1, LOCK stays 1.
REQ-033 Locked, full frame complete, next word 0x66 with FS=0 -> ERR pulse, no QV, LOCK drops, Q unchanged.
REQ-034 Frame with DV=0 gaps of 3 cycles between words -> identical Q/QV sequence to REQ-030, delayed only by the gaps.
REQ-035 RN asserted asynchronously after slot 1 -> all outputs 0 immediately; after release, the remaining frame words are discarded until the next FS.
